// File: rtl/leiwand_rv32_sram.sv
// leiwand_rv32_sram: windowed single-port word memory with wait states and error responses (clk, reset, valid/wen/addr/wdata in; ready/rdata/err out)
module leiwand_rv32_sram #(
  parameter int          WORDS      = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h20400000,
  parameter int          READ_WAIT  = 0,
  parameter int          WRITE_WAIT = 0,
  parameter bit          READ_ONLY  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [31:0] mem [0:WORDS-1];
  logic [3:0] cnt, wen_q, wsel, a_wen;
  logic [31:0] wdata_q, off, a_wdata;
  logic [IW-1:0] idx_q, a_idx;
  logic [32:0] lo, hi;
  logic hit, hit_q, a_hit, ok, go_resp, accept, unused_off;
  assign lo         = {1'b0, BASE_ADDR};
  assign hi         = lo + (33'(WORDS) << 2);
  assign hit        = {1'b0, addr} >= lo && {1'b0, addr} < hi;
  assign off        = addr - BASE_ADDR;
  assign unused_off = ^{off[1:0], off[31:IW+2]};
  assign wsel       = wen == 4'd0 ? 4'(READ_WAIT) : 4'(WRITE_WAIT);
  assign accept     = state == IDLE && valid;
  // A zero-wait access acts on the live inputs in the same edge that latches them.
  assign a_wen      = state == IDLE ? wen : wen_q;
  assign a_wdata    = state == IDLE ? wdata : wdata_q;
  assign a_idx      = state == IDLE ? off[IW+1:2] : idx_q;
  assign a_hit      = state == IDLE ? hit : hit_q;
  assign ok         = a_hit && !(READ_ONLY && a_wen != 4'd0);
  assign go_resp    = (accept && wsel == 4'd0) || (state == WAIT && cnt == 4'd1);
  always_ff @(posedge clk)
    if (!reset && go_resp && ok && a_wen != 4'd0)
      for (int i = 0; i < 4; i++)
        if (a_wen[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= go_resp;
      err   <= go_resp && !ok;
      if (go_resp) rdata <= !ok ? 32'd0 : a_wen == 4'd0 ? mem[a_idx] : rdata;
      cnt   <= accept ? wsel : state == WAIT ? cnt - 4'd1 : cnt;
      state <= state == IDLE ? (valid ? (wsel == 4'd0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    end
    if (accept) begin
      wen_q   <= wen;
      wdata_q <= wdata;
      idx_q   <= off[IW+1:2];
      hit_q   <= hit;
    end
  end
endmodule

// File: tb/tb_leiwand_rv32_sram.sv
// tb_leiwand_rv32_sram: directed bench for plain, wait-state and read-only memory instances
module tb_leiwand_rv32_sram;
  logic clk = 1'b0, reset = 1'b0;
  logic [2:0] valid = 3'b000;
  logic [3:0] wen = 4'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [2:0] rdy, errv;
  logic [31:0] rdv [0:2];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  leiwand_rv32_sram dut0 (.clk(clk), .reset(reset), .valid(valid[0]), .ready(rdy[0]), .wen(wen),
    .addr(addr), .wdata(wdata), .rdata(rdv[0]), .err(errv[0]));
  leiwand_rv32_sram #(.READ_WAIT(3), .WRITE_WAIT(2)) dut1 (.clk(clk), .reset(reset), .valid(valid[1]),
    .ready(rdy[1]), .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdv[1]), .err(errv[1]));
  leiwand_rv32_sram #(.READ_ONLY(1'b1)) dut2 (.clk(clk), .reset(reset), .valid(valid[2]), .ready(rdy[2]),
    .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdv[2]), .err(errv[2]));

  task automatic req(input int s, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    addr = a; wen = w; wdata = d; valid[s] = 1'b1;
    lat = -1; rd = 32'hx; e = 1'bx;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (rdy[s]) begin
        lat = i; rd = rdv[s]; e = errv[s]; valid[s] = 1'b0;
      end
    end
    valid[s] = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] csum0();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 4096; i++) s = s + dut0.mem[i];
    return s;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) begin
      dut0.mem[i] = 32'(i * 3 + 7);
      dut1.mem[i] = 32'd0;
      dut2.mem[i] = 32'd0;
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tests++;
      if ({rdy[s], errv[s], rdv[s]} !== 34'd0) begin
        fails++; $display("FAIL reset dut%0d: ready=%b err=%b rdata=%h, want 0/0/0", s, rdy[s], errv[s], rdv[s]);
      end
    end
  endtask

  task automatic test_read();
    int lat; logic [31:0] rd; logic e;
    dut0.mem[1] = 32'hDEADBEEF;
    req(0, 32'h20400004, 4'd0, 32'd0, lat, rd, e);
    tests++; if (lat !== 0) begin fails++; $display("FAIL read latency: got %0d want 0", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL read rdata: got %h want deadbeef", rd); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL read err: got %b want 0", e); end
    tests++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL read pulse width: ready=%b want 0", rdy[0]); end
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] rd; logic e;
    dut0.mem[2] = 32'h11223344;
    req(0, 32'h20400008, 4'b0101, 32'hAABBCCDD, lat, rd, e);
    tests++; if (lat !== 0 || e !== 1'b0) begin fails++; $display("FAIL write resp: lat=%0d err=%b want 0/0", lat, e); end
    tests++; if (dut0.mem[2] !== 32'h11BB33DD) begin fails++; $display("FAIL write mem: got %h want 11bb33dd", dut0.mem[2]); end
    tests++; if (rdv[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL write rdata hold: got %h want deadbeef", rdv[0]); end
    req(0, 32'h2040000A, 4'd0, 32'd0, lat, rd, e);
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL write readback: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_read_wait();
    int lat; logic [31:0] rd; logic e;
    dut1.mem[0] = 32'hCAFE0001;
    req(1, 32'h20400000, 4'd0, 32'd0, lat, rd, e);
    tests++; if (lat !== 3) begin fails++; $display("FAIL wait latency: got %0d want 3", lat); end
    tests++; if (rd !== 32'hCAFE0001 || e !== 1'b0) begin fails++; $display("FAIL wait rdata: got %h/%b want cafe0001/0", rd, e); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, c0; logic e;
    c0 = csum0();
    req(0, 32'h20404000, 4'd0, 32'd0, lat, rd, e);
    tests++; if (lat !== 0 || e !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL oor top: lat=%0d err=%b rdata=%h want 0/1/0", lat, e, rd); end
    tests++; if (errv[0] !== 1'b0) begin fails++; $display("FAIL oor err after: got %b want 0", errv[0]); end
    req(0, 32'h1FFFFFFC, 4'd0, 32'd0, lat, rd, e);
    tests++; if (lat !== 0 || e !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL oor below: lat=%0d err=%b rdata=%h want 0/1/0", lat, e, rd); end
    req(0, 32'h20404000, 4'hF, 32'h12345678, lat, rd, e);
    tests++; if (lat !== 0 || e !== 1'b1) begin fails++; $display("FAIL oor write: lat=%0d err=%b want 0/1", lat, e); end
    tests++; if (csum0() !== c0) begin fails++; $display("FAIL oor checksum: got %h want %h", csum0(), c0); end
  endtask

  task automatic test_reset_during_wait();
    int lat; logic [31:0] rd; logic e; logic seen = 1'b0;
    dut1.mem[3] = 32'h00000055;
    @(negedge clk);
    addr = 32'h2040000C; wen = 4'hF; wdata = 32'h00000099; valid[1] = 1'b1;
    @(negedge clk);
    reset = 1'b1; valid[1] = 1'b0;
    @(posedge clk); #1;
    tests++; if ({rdy[1], errv[1], rdv[1]} !== 34'd0) begin fails++; $display("FAIL abort outputs: ready=%b err=%b rdata=%h want 0/0/0", rdy[1], errv[1], rdv[1]); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; seen |= rdy[1]; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort pulse: ready seen=%b want 0", seen); end
    tests++; if (dut1.mem[3] !== 32'h00000055) begin fails++; $display("FAIL abort mem: got %h want 00000055", dut1.mem[3]); end
    req(1, 32'h2040000C, 4'd0, 32'd0, lat, rd, e);
    tests++; if (lat !== 3) begin fails++; $display("FAIL abort next latency: got %0d want 3", lat); end
    tests++; if (rd !== 32'h00000055 || e !== 1'b0) begin fails++; $display("FAIL abort next rdata: got %h/%b want 00000055/0", rd, e); end
  endtask

  task automatic test_read_only();
    logic [2:0] rp, ep;
    dut2.mem[0] = 32'h12345678;
    @(negedge clk);
    addr = 32'h20400000; wen = 4'hF; wdata = 32'hFFFFFFFF; valid[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; rp[i] = rdy[2]; ep[i] = errv[2]; end
    valid[2] = 1'b0;
    @(posedge clk); #1;
    tests++; if (rp !== 3'b101) begin fails++; $display("FAIL ro ready pattern: got %b want 101", rp); end
    tests++; if (ep !== 3'b101) begin fails++; $display("FAIL ro err pattern: got %b want 101", ep); end
    tests++; if (rdv[2] !== 32'd0) begin fails++; $display("FAIL ro rdata: got %h want 0", rdv[2]); end
    tests++; if (dut2.mem[0] !== 32'h12345678) begin fails++; $display("FAIL ro mem: got %h want 12345678", dut2.mem[0]); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_read_wait();
    test_out_of_range();
    test_reset_during_wait();
    test_read_only();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
